// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared state type and default slice width for the sliced adder
package seq_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t;
  localparam int SLICE_DEF = 4;
endpackage

// File: rtl/slice_cpa.sv
// slice_cpa: combinational SLICE-bit carry-propagate adder reused by every slice step
module slice_cpa #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};
endmodule

// File: rtl/seq_slice_adder.sv
// seq_slice_adder: WIDTH-bit adder computed one SLICE-bit slice per clock, LSB first,
// with valid/ready handshakes on operand and result sides.
module seq_slice_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int NSLICES = WIDTH / SLICE;
  localparam int IW = NSLICES > 1 ? $clog2(NSLICES) : 1;
  if (WIDTH <= 0 || SLICE <= 0 || WIDTH % SLICE != 0) begin : g_bad_width
    $error("seq_slice_adder: WIDTH must be a positive multiple of SLICE");
  end
  adder_state_t state, state_nx;
  logic [IW-1:0] idx;
  logic carry, last, sl_co;
  logic [WIDTH-1:0] a_r, b_r;
  logic [SLICE-1:0] sl_s;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = idx == IW'(NSLICES - 1);
  slice_cpa #(.SLICE(SLICE)) u_cpa (
    .a(a_r[idx*SLICE +: SLICE]),
    .b(b_r[idx*SLICE +: SLICE]),
    .c_in(carry),
    .s(sl_s),
    .c_out(sl_co)
  );
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && in_valid) ? RUN :
               (state == RUN && last)      ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // The carry register doubles as the c_in holder until the first slice runs.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      c_out <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_r <= a;
      b_r <= b;
      carry <= c_in;
      idx <= '0;
    end else if (state == RUN) begin
      sum[idx*SLICE +: SLICE] <= sl_s;
      carry <= sl_co;
      idx <= last ? '0 : idx + 1'b1;
      c_out <= last ? sl_co : c_out;
    end
endmodule

// File: tb/tb_seq_slice_adder.sv
// tb_seq_slice_adder: directed and random scoreboard checks of the sliced adder.
module tb_seq_slice_adder;
  logic clk = 0, reset = 1, in_valid = 0, c_in = 0, out_ready = 1;
  logic in_ready, out_valid, c_out;
  logic [15:0] a = 0, b = 0, sum;
  int total = 0, bad = 0, n_in = 0, n_out = 0;
  bit rand_mode = 0, done_rand = 0;
  logic [16:0] exp_q[$];

  seq_slice_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c_in});
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_result", {c_out, sum}, 17'h1ffff);
        else check("scoreboard", {c_out, sum}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("send_timeout", {16'd0, in_ready}, 17'd1);
    a = x; b = y; c_in = ci; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) check("out_timeout", {16'd0, out_valid}, 17'd1);
  endtask

  initial begin
    int n;
    #12;
    check("rst_in_ready", {16'd0, in_ready}, 17'd1);
    check("rst_out_valid", {16'd0, out_valid}, 17'd0);
    check("rst_result", {c_out, sum}, 17'd0);
    @(posedge clk); #1; reset = 0;

    send(16'h0004, 16'h0005, 0);
    wait_out(n);
    check("latency", n, 4);
    check("sum_4_5", {c_out, sum}, 17'h00009);
    @(posedge clk); #1;
    send(16'h000F, 16'h0001, 1); wait_out(n);
    check("slice_carry", {c_out, sum}, 17'h00011);
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0000, 1); wait_out(n);
    check("ripple_all", {c_out, sum}, 17'h10000);
    @(posedge clk); #1;
    send(16'h8000, 16'h8000, 0); wait_out(n);
    check("msb_carry", {c_out, sum}, 17'h10000);
    @(posedge clk); #1;

    out_ready = 0;
    send(16'h00A5, 16'h0F0F, 1); wait_out(n);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = 1;
      @(posedge clk); #1;
      check("bp_hold", {c_out, sum}, 17'h00FB5);
      check("bp_in_ready", {16'd0, in_ready}, 17'd0);
      check("bp_out_valid", {16'd0, out_valid}, 17'd1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check("bp_release_ov", {16'd0, out_valid}, 17'd0);
    check("bp_release_ir", {16'd0, in_ready}, 17'd1);

    send(16'hABCD, 16'h1111, 1);
    @(posedge clk); #1;
    reset = 1; #1;
    check("mid_rst_ov", {16'd0, out_valid}, 17'd0);
    check("mid_rst_res", {c_out, sum}, 17'd0);
    check("mid_rst_ir", {16'd0, in_ready}, 17'd1);
    @(posedge clk); #1; reset = 0;
    n_in = 0; n_out = 0;
    send(16'h1234, 16'h4321, 0); wait_out(n);
    check("post_rst", {c_out, sum}, 17'h05555);
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 1000; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom));
        done_rand = 1;
      end
      while (!done_rand) begin
        @(posedge clk); #1;
        out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("drain", exp_q.size(), 0);
    check("count_match", n_out, n_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
